data_mem_responder: RTL

//  Responder side of the MEM-stage data-memory interface. It accepts one load/store request
//  at a time from the mem stage, inserts a programmable number of wait states, applies
//  big-endian byte-enables and returns read data with a one-cycle ack pulse.
//  It drives stallreq_o so the pipeline control can freeze earlier stages until ack.

---
 rtl/data_mem_responder_pkg.sv | 47 ++++
 rtl/data_ram_array.sv | 31 +++
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
//   dm_state_t : responder FSM encoding (IDLE / WAIT / RESP)
//   dm_req_t   : one latched load/store request
//   lane_mask  : expands a big-endian byte-select into a 32-bit lane mask
//   req_error  : out-of-range / misaligned / empty-select detection
package data_mem_responder_pkg;

  localparam int          BYTE_LANES = 4;
  localparam int          CNT_W      = 4;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } dm_req_t;

  // sel[3] is byte offset 0, which lives in data[31:24]; sel[i] therefore
  // always maps onto data[8*i+7:8*i].
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] mask;
    for (int i = 0; i < BYTE_LANES; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

  // A request is rejected when any address bit above the word index is set,
  // when a full-word access is not word aligned, or when no lane is selected.
  function automatic logic req_error(input logic [31:0] addr,
                                     input logic [3:0]  sel,
                                     input int          addr_w);
    logic out_of_range;
    logic misaligned;
    out_of_range = (addr >> (addr_w + 2)) != 32'd0;
    misaligned   = (addr[1:0] != 2'b00) && (sel == 4'b1111);
    return out_of_range || misaligned || (sel == 4'b0000);
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables.
//   clk   : clock
//   we    : byte-lane write enables, we[i] writes wdata[8*i+7:8*i]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
// Contents are deliberately not reset.
module data_ram_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the MEM-stage data-memory interface. Accepts one request at a
// time, waits WAIT_CYCLES, commits the access and pulses ack_o for one cycle.
//   clk, rst    : clock, synchronous active-high reset
//   ce_i        : request valid, held by the requester until ack_o
//   we_i        : 1 = store, 0 = load
//   addr_i      : byte address
//   sel_i       : big-endian byte enables (sel_i[3] = data[31:24])
//   data_i      : store data
//   data_o      : load data, valid with ack_o and held until the next ack
//   ack_o       : one-cycle completion pulse
//   err_o       : qualifies ack_o for rejected accesses
//   stallreq_o  : freeze request to pipeline control (ce_i & ~ack_o)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stallreq_o
);

  dm_state_t        state;
  dm_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  dm_req_t     req_q;
  dm_req_t     eff;
  logic        eff_err;
  logic        err_q;
  logic [31:0] hold_q;
  logic        commit;
  logic        wr_commit;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  // In IDLE the request being accepted has not been latched yet; with zero
  // wait states it commits on that same edge, so the live inputs stand in for
  // the latched copy. Elsewhere only the latched copy is used.
  assign eff     = (state == DM_IDLE) ? dm_req_t'{we_i, addr_i, sel_i, data_i} : req_q;
  assign eff_err = req_error(eff.addr, eff.sel, ADDR_W);

  // RESP never re-enters itself, so every transition into it is a commit.
  assign commit    = (state_next == DM_RESP);
  assign wr_commit = commit & eff.we & ~eff_err & ~rst;

  generate
    for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane_we
      assign ram_we[gi] = wr_commit & eff.sel[gi];
    end
  endgenerate

  // The read address is presented in the cycle before RESP, so the registered
  // RAM output lands exactly in the ack cycle.
  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (eff.addr[ADDR_W+1:2]),
    .wdata (eff.data),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      DM_IDLE: begin
        if (ce_i) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DM_RESP;
          end else begin
            state_next = DM_WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      DM_WAIT: begin
        if (!ce_i) begin
          state_next = DM_IDLE;
        end else if (cnt == '0) begin
          state_next = DM_RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DM_RESP: state_next = DM_IDLE;
      default: state_next = DM_IDLE;
    endcase
  end

  // Request latch, error flag and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      err_q  <= 1'b0;
      hold_q <= ZERO_WORD;
    end else begin
      if (state == DM_IDLE && ce_i) begin
        req_q <= eff;
      end
      if (commit) begin
        err_q <= eff_err;
      end
      if (state == DM_RESP) begin
        hold_q <= data_o;
      end
    end
  end

  // Outputs
  always_comb begin
    ack_o  = (state == DM_RESP);
    err_o  = 1'b0;
    data_o = hold_q;
    if (state == DM_RESP) begin
      err_o = err_q;
      if (err_q) begin
        data_o = ZERO_WORD;
      end else if (!req_q.we) begin
        data_o = ram_rdata & lane_mask(req_q.sel);
      end
    end
  end

  assign stallreq_o = ce_i & ~ack_o & ~rst;

endmodule
